// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: arbitrates PTW/load/store ports onto one data-cache controller, one transaction in flight.
// Define DCACHE_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module dcache_req_arbiter #(
   parameter int NUM_PORTS  = 3,
   parameter int ADDR_WIDTH = 34
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_PORTS-1:0]            req_i,
   output logic [NUM_PORTS-1:0]            gnt_o,
   input  logic [NUM_PORTS-1:0]            we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_PORTS*32-1:0]         wdata_i,
   input  logic [NUM_PORTS*4-1:0]          be_i,
   input  logic [NUM_PORTS*2-1:0]          size_i,
   input  logic [NUM_PORTS-1:0]            kill_i,
   output logic [NUM_PORTS-1:0]            rvalid_o,
   output logic [31:0]                     rdata_o,
   output logic                            cache_req_o,
   input  logic                            cache_gnt_i,
   output logic [ADDR_WIDTH-1:0]           cache_addr_o,
   output logic                            cache_we_o,
   output logic [31:0]                     cache_wdata_o,
   output logic [3:0]                      cache_be_o,
   output logic [1:0]                      cache_size_o,
   output logic [1:0]                      cache_port_o,
   input  logic                            cache_done_i,
   input  logic [31:0]                     cache_rdata_i
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                r_state, w_next;
   logic [PW-1:0]         w_win, r_port;
   logic                  w_any, w_grant, w_kill, w_done;
   logic                  r_we, r_killed;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic [1:0]            r_size;

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
   logic [PW-1:0] r_ptr, w_idx;

   // Descending scan so the port closest to the pointer is the last (winning) assignment.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         w_idx = PW'((int'(r_ptr) + k) % NUM_PORTS);
         if (req_i[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_ptr <= '0;
      else if (w_grant) r_ptr <= (int'(w_win) == NUM_PORTS - 1) ? '0 : w_win + 1'b1;
`else
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            w_any = 1'b1;
            w_win = PW'(k);
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_state <= S_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = w_any ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next = cache_gnt_i ? S_WAIT : (w_kill ? S_IDLE : S_ISSUE);
         S_WAIT:  w_next = cache_done_i ? S_IDLE : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end

   // Grant is gated by reset so requesters never see a grant while the arbiter is held.
   always_comb begin
      w_kill      = kill_i[r_port];
      w_grant     = rst_ni && r_state == S_IDLE && w_any;
      w_done      = r_state == S_WAIT && cache_done_i && !r_killed && !w_kill;
      gnt_o       = '0;
      gnt_o[w_win] = w_grant;
      rvalid_o    = '0;
      rvalid_o[r_port] = w_done;
      rdata_o     = (w_done && !r_we) ? cache_rdata_i : 32'd0;
      cache_req_o = r_state == S_ISSUE;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_port   <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_size   <= '0;
         r_killed <= 1'b0;
      end else if (w_grant) begin
         r_port   <= w_win;
         r_we     <= we_i[w_win];
         r_addr   <= addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
         r_wdata  <= wdata_i[w_win*32 +: 32];
         r_be     <= be_i[w_win*4 +: 4];
         r_size   <= size_i[w_win*2 +: 2];
         r_killed <= 1'b0;
      end else if (w_kill && (r_state == S_WAIT || (r_state == S_ISSUE && cache_gnt_i))) begin
         r_killed <= 1'b1;
      end

   assign cache_addr_o  = r_addr;
   assign cache_we_o    = r_we;
   assign cache_wdata_o = r_wdata;
   assign cache_be_o    = r_be;
   assign cache_size_o  = r_size;
   assign cache_port_o  = 2'(r_port);
endmodule
